hit_key_conditioner: RTL and testbench

//   Conditions the raw active-low player push key (GPIO[0]) for the rhythm-game datapath.

---
 rtl/hit_key_conditioner.sv | 162 ++++++++++++++++
 tb/tb_hit_key_conditioner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_key_conditioner.sv
// hit_key_conditioner
//   Conditions the raw active-low player push key for the rhythm-game datapath.
//   The key is synchronised into the clk domain and debounced by a four-state
//   FSM. Each clean press is latched as a pending hit, which is held on hit_n
//   until the next beat_tick consumes it. Captured presses are also counted.
//
// Ports
//   clk          in   CLOCK_50, sole clock
//   rst          in   asynchronous, active-low reset
//   key_n        in   raw push key, low = pressed, asynchronous to clk
//   beat_tick    in   one-clk pulse per game step
//   enable       in   game running; gates hit capture
//   hit_n        out  pending hit to the datapath button input, low = pending
//   key_down     out  debounced key level, 1 = pressed
//   press_pulse  out  one-clk pulse on each debounced press
//   press_count  out  8-bit saturating count of captured hits
module hit_key_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       beat_tick,
    input  logic       enable,
    output logic       hit_n,
    output logic       key_down,
    output logic       press_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_FALL = 2'd1,
        ST_DOWN = 2'd2,
        ST_RISE = 2'd3
    } deb_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   key_down_q, key_down_d;
    logic                   press_pulse_q, press_pulse_d;
    logic                   pend_q, pend_d;
    logic [7:0]             press_count_q, press_count_d;
    logic                   ks;
    logic                   capture;

    // Synchroniser shift chain; flops reset to the idle (released) level so a
    // held key after reset is seen as a fresh falling edge.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
    end

    assign ks = sync_q[SYNC_STAGES-1];

    // Debounce FSM. The transitional states count how long the new level has
    // been stable; any bounce back returns to the settled state and the count
    // restarts from zero on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_UP: begin
                if (!ks) begin
                    state_d = ST_FALL;
                    cnt_d   = '0;
                end
            end
            ST_FALL: begin
                if (ks) begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (ks) begin
                    state_d = ST_RISE;
                    cnt_d   = '0;
                end
            end
            ST_RISE: begin
                if (!ks) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_UP;
                cnt_d   = '0;
            end
        endcase
    end

    // RISE still counts as pressed, so a RISE->DOWN bounce leaves key_down_q
    // high and cannot fire press_pulse; only a genuine FALL->DOWN entry does,
    // one cycle after DOWN is reached.
    always_comb begin
        key_down_d    = (state_q == ST_DOWN) || (state_q == ST_RISE);
        press_pulse_d = (state_q == ST_DOWN) && !key_down_q;
    end

    // Hit latch. A press beats a coincident beat_tick so it is never lost;
    // extra presses before the beat merge into the same pending hit but are
    // still counted.
    assign capture = press_pulse_q && enable;

    always_comb begin
        pend_d        = pend_q;
        press_count_d = press_count_q;
        if (!enable) begin
            pend_d = 1'b0;
        end else if (capture) begin
            pend_d = 1'b1;
            if (press_count_q != 8'hFF) begin
                press_count_d = press_count_q + 8'd1;
            end
        end else if (beat_tick) begin
            pend_d = 1'b0;
        end
    end

    // All state registers share the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q        <= '1;
            state_q       <= ST_UP;
            cnt_q         <= '0;
            key_down_q    <= 1'b0;
            press_pulse_q <= 1'b0;
            pend_q        <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_down_q    <= key_down_d;
            press_pulse_q <= press_pulse_d;
            pend_q        <= pend_d;
            press_count_q <= press_count_d;
        end
    end

    assign hit_n       = ~pend_q;
    assign key_down    = key_down_q;
    assign press_pulse = press_pulse_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_hit_key_conditioner.sv
// tb_hit_key_conditioner
//   Directed bench for hit_key_conditioner with SYNC_STAGES=2 and
//   DEBOUNCE_CYCLES=4. A run-length behavioural model predicts every output
//   each cycle, and directed literal checks pin the model's timing.
module tb_hit_key_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_n = 1'b1;
    logic       beat_tick = 1'b0;
    logic       enable = 1'b1;
    logic       hit_n;
    logic       key_down;
    logic       press_pulse;
    logic [7:0] press_count;

    int vectors = 0;
    int miscompares = 0;

    hit_key_conditioner #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .key_n(key_n),
        .beat_tick(beat_tick),
        .enable(enable),
        .hit_n(hit_n),
        .key_down(key_down),
        .press_pulse(press_pulse),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: key_n delayed by the synchroniser, then the debounced
    // level flips once the opposite level has been seen for DEB+1 consecutive
    // edges. Outputs are the level delayed one edge and its rising edge.
    logic       kq [SYNC];
    logic       m_level;
    int         m_run;
    logic       m_kd;
    logic       m_pulse;
    logic       m_pend;
    logic [7:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        logic ks;
        logic new_kd;
        logic new_pulse;
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) kq[i] = 1'b1;
            m_level = 1'b0;
            m_run   = 0;
            m_kd    = 1'b0;
            m_pulse = 1'b0;
            m_pend  = 1'b0;
            m_cnt   = 8'd0;
        end else begin
            ks = kq[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) kq[i] = kq[i-1];
            kq[0] = key_n;
            new_kd    = m_level;
            new_pulse = m_level && !m_kd;
            if (!enable) begin
                m_pend = 1'b0;
            end else if (m_pulse) begin
                m_pend = 1'b1;
                if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
            end else if (beat_tick) begin
                m_pend = 1'b0;
            end
            if ((!ks) != m_level) begin
                m_run = m_run + 1;
                if (m_run == DEB + 1) begin
                    m_level = ~m_level;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_kd    = new_kd;
            m_pulse = new_pulse;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, required, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model_hit_n", {7'd0, hit_n}, {7'd0, ~m_pend});
            checkOutput("model_key_down", {7'd0, key_down}, {7'd0, m_kd});
            checkOutput("model_press_pulse", {7'd0, press_pulse}, {7'd0, m_pulse});
            checkOutput("model_press_count", press_count, m_cnt);
        end
    end

    task automatic applyStimulus(input logic k, input logic b, input logic e);
        key_n     = k;
        beat_tick = b;
        enable    = e;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset pulse entirely between two clock edges; outputs must clear at once.
    task automatic pulseReset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        checkOutput({tag, "_rst_hit_n"}, {7'd0, hit_n}, 8'd1);
        checkOutput({tag, "_rst_key_down"}, {7'd0, key_down}, 8'd0);
        checkOutput({tag, "_rst_pulse"}, {7'd0, press_pulse}, 8'd0);
        checkOutput({tag, "_rst_count"}, press_count, 8'd0);
        #1 rst_n = 1'b1;
    endtask

    task automatic doReset(input string tag);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitNeg(1);
        pulseReset(tag);
        waitNeg(2);
    endtask

    initial begin
        logic pulse_seen;

        // 1: clean press, hold, release
        doReset("t1");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(7);
        checkOutput("t1_pulse_e6", {7'd0, press_pulse}, 8'd0);
        checkOutput("t1_kd_e6", {7'd0, key_down}, 8'd0);
        waitNeg(1);
        checkOutput("t1_pulse_e7", {7'd0, press_pulse}, 8'd1);
        checkOutput("t1_kd_e7", {7'd0, key_down}, 8'd1);
        waitNeg(1);
        checkOutput("t1_pulse_e8", {7'd0, press_pulse}, 8'd0);
        waitNeg(11);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitNeg(7);
        checkOutput("t1_rel_kd_e6", {7'd0, key_down}, 8'd1);
        waitNeg(1);
        checkOutput("t1_rel_kd_e7", {7'd0, key_down}, 8'd0);
        checkOutput("t1_rel_pulse", {7'd0, press_pulse}, 8'd0);
        waitNeg(4);

        // 2: glitch shorter than the debounce window
        doReset("t2");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(3);
        applyStimulus(1'b1, 1'b0, 1'b1);
        pulse_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            waitNeg(1);
            if (press_pulse || key_down) pulse_seen = 1'b1;
        end
        checkOutput("t2_no_press", {7'd0, pulse_seen}, 8'd0);
        checkOutput("t2_count", press_count, 8'd0);

        // 3: press then beat 10 cycles later
        doReset("t3");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(9);
        checkOutput("t3_hit_e8", {7'd0, hit_n}, 8'd0);
        waitNeg(9);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t3_hit_in_tick", {7'd0, hit_n}, 8'd0);
        waitNeg(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3_hit_after_tick", {7'd0, hit_n}, 8'd1);
        checkOutput("t3_count", press_count, 8'd1);

        // 4: beat coincident with press_pulse; press wins
        doReset("t4");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(8);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitNeg(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4_hit_after_coinc", {7'd0, hit_n}, 8'd0);
        waitNeg(3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4_hit_next_tick", {7'd0, hit_n}, 8'd0);
        waitNeg(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4_hit_cleared", {7'd0, hit_n}, 8'd1);
        checkOutput("t4_count", press_count, 8'd1);

        // 5: enable low ignores presses; dropping enable clears pending hit
        doReset("t5");
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitNeg(8);
        checkOutput("t5_pulse", {7'd0, press_pulse}, 8'd1);
        waitNeg(1);
        checkOutput("t5_hit_dis", {7'd0, hit_n}, 8'd1);
        checkOutput("t5_count_dis", press_count, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitNeg(10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(9);
        checkOutput("t5_hit_en", {7'd0, hit_n}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitNeg(1);
        checkOutput("t5_hit_drop", {7'd0, hit_n}, 8'd1);
        checkOutput("t5_count_en", press_count, 8'd1);

        // 6: reset mid-FALL with key held, then saturation
        doReset("t6");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(9);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitNeg(10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(4);
        checkOutput("t6_pend_before", {7'd0, hit_n}, 8'd0);
        pulseReset("t6mid");
        waitNeg(7);
        checkOutput("t6_pulse_e6", {7'd0, press_pulse}, 8'd0);
        waitNeg(1);
        checkOutput("t6_pulse_e7", {7'd0, press_pulse}, 8'd1);
        waitNeg(1);
        checkOutput("t6_count_1", press_count, 8'd1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            waitNeg(10);
            applyStimulus(1'b0, 1'b0, 1'b1);
            waitNeg(10);
        end
        checkOutput("t6_count_sat", press_count, 8'd255);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitNeg(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
